// File: rtl/cam_match_encoder.sv
// Multi-match priority encoder for the exact-match CAM: latches one match-line
// vector and streams every hit address out, lowest index first.
module cam_match_encoder #(
  parameter int SIZE = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  match_valid_i,
  output logic                  match_ready_o,
  input  logic [(1<<SIZE)-1:0]  match_i,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic [SIZE-1:0]       addr_o,
  output logic                  last_o,
  output logic                  miss_o,
  output logic [SIZE:0]         count_o
);
  localparam int N = 1 << SIZE;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic            miss_q, miss_d;
  logic [SIZE:0]   count_q, count_d;

  logic [N-1:0]    pending_m1;
  logic [N-1:0]    pending_rest;
  logic [SIZE-1:0] lo_idx;
  logic [SIZE:0]   pop_cnt;
  logic            last_raw;
  logic            drain_vld;

  // Descending scan so the lowest set bit is the final (winning) assignment.
  always_comb begin
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) lo_idx = i[SIZE-1:0];
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + {{SIZE{1'b0}}, match_i[i]};
    end
  end

  assign pending_m1   = pending_q - N'(1);
  assign pending_rest = pending_q & pending_m1;
  assign last_raw     = miss_q | (pending_rest == '0);
  assign drain_vld    = !rst_i && (state_q == DRAIN);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    miss_d    = miss_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (match_valid_i) begin
          state_d = DRAIN;
          if (match_i != '0) begin
            pending_d = match_i;
            miss_d    = 1'b0;
            count_d   = pop_cnt;
          end else begin
            pending_d = '0;
            miss_d    = 1'b1;
            count_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (addr_ready_i) begin
          pending_d = pending_rest;
          if (last_raw) begin
            miss_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      miss_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      miss_q    <= miss_d;
      count_q   <= count_d;
    end
  end

  // Result fields read zero whenever no result is being presented.
  assign match_ready_o = !rst_i && (state_q == IDLE);
  assign addr_valid_o  = drain_vld;
  assign addr_o        = (drain_vld && !miss_q) ? lo_idx : '0;
  assign last_o        = drain_vld && last_raw;
  assign miss_o        = drain_vld && miss_q;
  assign count_o       = drain_vld ? count_q : '0;

endmodule

// File: tb/tb_cam_match_encoder.sv
// Randomized bench: each search is modelled as the ascending list of set bit
// indices, and the DUT stream is compared against that list entry by entry.
module tb_cam_match_encoder;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        match_valid_i, match_ready_o;
  logic [31:0] match_i;
  logic        addr_valid_o, addr_ready_i;
  logic [4:0]  addr_o;
  logic        last_o, miss_o;
  logic [5:0]  count_o;

  logic        m3_valid, m3_ready;
  logic [7:0]  m3_match;
  logic        a3_valid, a3_ready;
  logic [2:0]  a3_addr;
  logic        a3_last, a3_miss;
  logic [3:0]  a3_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cam_match_encoder #(.SIZE(5)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .match_valid_i(match_valid_i), .match_ready_o(match_ready_o), .match_i(match_i),
    .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .addr_o(addr_o), .last_o(last_o), .miss_o(miss_o), .count_o(count_o)
  );

  cam_match_encoder #(.SIZE(3)) dut3 (
    .clk_i(clk), .rst_i(rst_i),
    .match_valid_i(m3_valid), .match_ready_o(m3_ready), .match_i(m3_match),
    .addr_valid_o(a3_valid), .addr_ready_i(a3_ready),
    .addr_o(a3_addr), .last_o(a3_last), .miss_o(a3_miss), .count_o(a3_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pct >= 0: random consumer ready percentage; pct < 0: ready low for the
  // first 3 result cycles, then high.
  task automatic search(input logic [31:0] vec, input int pct, input string nm);
    int   exp_q[$];
    int   idx, cyc, n;
    bit   rdy, ms;
    logic [14:0] got, want;
    cyc = 0;
    while (!match_ready_o && cyc < 100) begin
      step();
      cyc++;
    end
    tests++;
    if (match_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL %s idle_wait got match_ready_o=%b want 1", nm, match_ready_o);
      return;
    end
    for (int k = 0; k < 32; k++) if (vec[k]) exp_q.push_back(k);
    ms = (exp_q.size() == 0);
    if (ms) exp_q.push_back(0);
    n = exp_q.size();
    match_i = vec; match_valid_i = 1'b1; addr_ready_i = 1'b0;
    step();
    match_valid_i = 1'b0; match_i = $urandom;
    idx = 0; cyc = 0;
    while (idx < n && cyc < 1000) begin
      got  = {addr_valid_o, match_ready_o, addr_o, last_o, miss_o, count_o};
      want = {1'b1, 1'b0, 5'(exp_q[idx]), (idx == n - 1), ms, 6'(ms ? 0 : n)};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s result[%0d] got {v,rdy,addr,last,miss,cnt}=%h want %h", nm, idx, got, want);
      end
      rdy = (pct < 0) ? (cyc >= 3) : ($urandom_range(0, 99) < pct);
      addr_ready_i  = rdy;
      match_valid_i = 1'($urandom_range(0, 1));
      match_i       = $urandom;
      step();
      if (rdy) idx++;
      cyc++;
    end
    match_valid_i = 1'b0; addr_ready_i = 1'b0;
    tests++;
    if (idx < n) begin
      fails++;
      $display("FAIL %s drain_timeout got %0d results want %0d", nm, idx, n);
    end
    tests++;
    if ({match_ready_o, addr_valid_o} !== 2'b10) begin
      fails++;
      $display("FAIL %s back_to_idle got ready,valid=%b%b want 10", nm, match_ready_o, addr_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; match_valid_i = 1'b0; match_i = '0; addr_ready_i = 1'b0;
    m3_valid = 1'b0; m3_match = '0; a3_ready = 1'b0;
    step(); step();
    tests++;
    if ({match_ready_o, addr_valid_o, addr_o, last_o, miss_o, count_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 0",
               {match_ready_o, addr_valid_o, addr_o, last_o, miss_o, count_o});
    end
    rst_i = 1'b0;
    step();
    tests++;
    if ({match_ready_o, addr_valid_o} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release got ready,valid=%b%b want 10", match_ready_o, addr_valid_o);
    end
  endtask

  task automatic test_directed();
    search(32'h0000_0100, 100, "single_hit");
    search(32'h8000_0015, 100, "multi_hit");
    search(32'h0000_0000, 100, "miss");
    search(32'h0000_0006, -1,  "backpressure");
    search(32'hFFFF_FFFF, 100, "full_vector");
    search(32'hFFFF_FFFF, 50,  "full_vector_bp");
    search(32'h8000_0000, 100, "top_bit");
    search(32'h0000_0001, 100, "bottom_bit");
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int t = 0; t < 40; t++) begin
      case (t % 4)
        0: v = $urandom;
        1: v = $urandom & $urandom & $urandom;
        2: v = 32'(1) << $urandom_range(0, 31);
        default: v = (t % 8 == 3) ? 32'h0 : ~($urandom & $urandom);
      endcase
      search(v, (t % 3 == 0) ? 100 : 40, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) search($urandom & $urandom, 100, "back_to_back");
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    seen = 0;
    match_i = 32'h0101_0101; match_valid_i = 1'b1; addr_ready_i = 1'b1;
    step();
    match_valid_i = 1'b0;
    while (seen < 2) begin
      tests++;
      if (addr_valid_o !== 1'b1 || addr_o !== 5'(8 * seen)) begin
        fails++;
        $display("FAIL mid_drain_result[%0d] got v=%b addr=%0d want v=1 addr=%0d",
                 seen, addr_valid_o, addr_o, 8 * seen);
      end
      seen++;
      if (seen == 2) rst_i = 1'b1;
      step();
    end
    tests++;
    if ({match_ready_o, addr_valid_o, addr_o, last_o, miss_o, count_o} !== '0) begin
      fails++;
      $display("FAIL mid_drain_reset got %b want 0",
               {match_ready_o, addr_valid_o, addr_o, last_o, miss_o, count_o});
    end
    rst_i = 1'b0; addr_ready_i = 1'b0;
    step();
    tests++;
    if ({match_ready_o, addr_valid_o} !== 2'b10) begin
      fails++;
      $display("FAIL mid_drain_release got ready,valid=%b%b want 10", match_ready_o, addr_valid_o);
    end
    search(32'h0000_0001, 100, "after_reset");
  endtask

  task automatic test_size3();
    logic [7:0] v;
    int exp_q[$];
    int idx, cyc;
    for (int t = 0; t < 5; t++) begin
      v = (t == 0) ? 8'hFF : 8'($urandom | 1);
      exp_q.delete();
      for (int k = 0; k < 8; k++) if (v[k]) exp_q.push_back(k);
      m3_match = v; m3_valid = 1'b1; a3_ready = 1'b1;
      step();
      m3_valid = 1'b0;
      idx = 0; cyc = 0;
      while (idx < exp_q.size() && cyc < 50) begin
        tests++;
        if ({a3_valid, a3_addr, a3_last, a3_count} !==
            {1'b1, 3'(exp_q[idx]), (idx == exp_q.size() - 1), 4'(exp_q.size())}) begin
          fails++;
          $display("FAIL size3[%0d] got v=%b addr=%0d last=%b cnt=%0d want addr=%0d cnt=%0d",
                   idx, a3_valid, a3_addr, a3_last, a3_count, exp_q[idx], exp_q.size());
        end
        step();
        idx++; cyc++;
      end
      tests++;
      if (m3_ready !== 1'b1) begin
        fails++;
        $display("FAIL size3_idle got ready=%b want 1", m3_ready);
      end
    end
    a3_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_drain();
    test_size3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cam_match_encoder.md
# cam_match_encoder

Multi-match priority encoder for the exact-match CAM: the reverse direction of the write-path one-hot address decoder. It accepts a 2**SIZE-bit match-line vector from one CAM search, latches it, and returns every matching entry address one per cycle, lowest index first, over a valid/ready stream. A search with no hits returns a single miss response. The block sits between the CAM match-line array and the result stream consumed by the query controller.

## Interface
- SIZE, 5, address width; the CAM has 2**SIZE entries (32 by default)
- clk_i  input  1  clock; all state changes on its rising edge
- rst_i  input  1  synchronous reset, active-high
- match_valid_i  input  1  match vector on match_i is valid
- match_ready_o  output  1  block can accept a new match vector
- match_i  input  2**SIZE  match lines; bit k set means entry k hit
- addr_valid_o  output  1  a result is presented on addr_o/last_o/miss_o/count_o
- addr_ready_i  input  1  consumer accepts the current result
- addr_o  output  SIZE  encoded entry address of the current hit; 0 on a miss
- last_o  output  1  current result is the final one for this search
- miss_o  output  1  search had no hits; addr_o is 0
- count_o  output  SIZE+1  number of hits latched for this search; 0 on a miss

## Operation
- Registers: state (IDLE, DRAIN), pending[2**SIZE-1:0], miss_q, count_q[SIZE:0].
- IDLE: match_ready_o=1, addr_valid_o=0. On match_valid_i && match_ready_o:
  - match_i != 0: pending <= match_i, miss_q <= 0, count_q <= popcount(match_i), go to DRAIN.
  - match_i == 0: pending <= 0, miss_q <= 1, count_q <= 0, go to DRAIN.
- DRAIN: match_ready_o=0, addr_valid_o=1.
  - addr_o = index of lowest set bit of pending; 0 when miss_q=1.
  - last_o = miss_q OR pending has exactly one bit set (pending & (pending-1) == 0).
  - miss_o = miss_q; count_o = count_q, constant for the whole drain.
  - On addr_valid_o && addr_ready_i: clear bit addr_o in pending (pending <= pending & (pending-1)). If last_o was 1, clear miss_q and go to IDLE; otherwise stay in DRAIN.
  - addr_ready_i low: all outputs held stable; no state change.
- match_valid_i and match_i are ignored outside the IDLE handshake; a vector is sampled only at the accept edge, so match_i may change freely afterwards.
- popcount is full width: all 2**SIZE bits set gives count_o = 2**SIZE (needs SIZE+1 bits).
- Results are strictly ascending in address; no address is ever repeated or skipped within one search.

## Timing
- Reset (rst_i high at an edge): state=IDLE, pending=0, miss_q=0, count_q=0. While rst_i is high, match_ready_o=0 and addr_valid_o=0; addr_o, last_o, miss_o and count_o read 0. Reset mid-drain drops all outstanding results, and the first edge with rst_i low behaves as IDLE.
- Accept at edge N: addr_valid_o=1 from cycle N+1. Latency from accept to first result is 1 cycle.
- With addr_ready_i held high, a search with k hits yields results in cycles N+1..N+k. match_ready_o returns to 1 in cycle N+k+1, so each search costs k+1 cycles, and a miss costs 2 cycles.
- match_ready_o and addr_valid_o are never both 1. There is no combinational path from addr_ready_i to match_ready_o, and none from match_valid_i to any output.
- The priority encode is combinational from pending; its 32-to-5 logic depth must close at the target clock without an extra pipeline stage.

## Test plan
- Single hit: match_i=32'h0000_0100 accepted at edge N -> cycle N+1: addr_o=8, last_o=1, miss_o=0, count_o=1; match_ready_o=1 in cycle N+2.
- Multi-hit in order: match_i=32'h8000_0015, ready held high -> addr_o sequence 0, 2, 4, 31 in consecutive cycles; last_o=1 only on 31; count_o=4 throughout.
- Miss: match_i=0 -> one result with miss_o=1, addr_o=0, last_o=1, count_o=0; back to IDLE the next cycle.
- Backpressure: match_i=32'h0000_0006, addr_ready_i low for 3 cycles after the first result -> addr_o=1 held stable for 4 cycles, then 2 with last_o=1. Pulsing match_valid_i during the drain has no effect.
- Full vector: match_i=32'hFFFF_FFFF -> 32 results with addresses 0..31, count_o=32, last_o only on 31; then SIZE=3 with match_i=8'hFF gives count_o=8.
- Reset mid-drain: rst_i high after the 2nd of 4 results -> in the next cycle addr_valid_o=0 and match_ready_o=0. After release, match_ready_o=1, and a new search 32'h0000_0001 returns addr_o=0, count_o=1 with no stale results.
